char_sequencer: RTL and testbench

//   Character source for the animated 7-segment display path: holds a short message in a

---
 rtl/char_seq_pkg.sv | 21 ++
 rtl/char_seq_buffer.sv | 38 +++
 rtl/char_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_char_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_seq_pkg.sv
// -----------------------------------------------------------------------------
// char_seq_pkg
//   Shared definitions for the character sequencer: character width and type,
//   the FSM state encoding and the blank character sent on a loop gap.
//   Optional feature macro used by the design: CHAR_SEQ_BLANK_GAP_EN.
// -----------------------------------------------------------------------------
package char_seq_pkg;

  localparam int CHAR_W = 7;

  typedef logic [CHAR_W-1:0] char_t;

  // FSM state encoding (ST_GAP is only reachable with CHAR_SEQ_BLANK_GAP_EN)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  localparam char_t BLANK_CHAR = 7'h20;

endpackage

// File: rtl/char_seq_buffer.sv
// -----------------------------------------------------------------------------
// char_seq_buffer
//   DEPTH x 7-bit message register file, one synchronous write port and one
//   asynchronous read port. A read of an address written in the same cycle
//   returns the old contents (the write lands on the clock edge).
// Ports
//   clk_i      system clock
//   wr_en_i    write strobe
//   wr_addr_i  write address
//   wr_data_i  character to store
//   rd_addr_i  read address
//   rd_data_o  character at rd_addr_i
// Contents are intentionally not reset.
// -----------------------------------------------------------------------------
module char_seq_buffer
  import char_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  char_t                    wr_data_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output char_t                    rd_data_o
);

  char_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/char_sequencer.sv
// -----------------------------------------------------------------------------
// char_sequencer
//   Plays a message held in a small register buffer out one character at a
//   time on a strobed char interface, paced by a 60 Hz tick pulse. Optional
//   continuous looping until stop.
// Ports
//   clk          system clock (rising edge)
//   reset        synchronous active-high reset
//   tick60       one-clk pace pulse
//   wr_en/wr_addr/wr_data   buffer write port (accepted in every state)
//   start        begin playback (ignored while busy)
//   start_len    characters to play, clamped to DEPTH
//   loop         sampled with start: repeat message until stop
//   stop         abort playback, highest priority
//   char_valid   one-clk strobe marking a new character on char_out
//   char_out     current character, held between strobes
//   busy         high whenever the FSM is not IDLE
//   done         one-clk pulse when a non-looping playback completes
//   dbg_state    current FSM state (char_seq_pkg ST_* encoding)
// Build option
//   CHAR_SEQ_BLANK_GAP_EN: on a loop wrap, emit BLANK_CHAR and hold it for
//   HOLD_TICKS ticks before restarting at index 0.
// Handshake: char_valid is a pure strobe with no back-pressure; the receiver
//   must take char_out in every cycle char_valid is high.
// -----------------------------------------------------------------------------
module char_sequencer
  import char_seq_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int HOLD_TICKS = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick60,
  input  logic                   wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [CHAR_W-1:0]      wr_data,
  input  logic                   start,
  input  logic [$clog2(DEPTH):0] start_len,
  input  logic                   loop,
  input  logic                   stop,
  output logic                   char_valid,
  output logic [CHAR_W-1:0]      char_out,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [HW-1:0] HOLD_L  = HW'(HOLD_TICKS);

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          loop_q, loop_d;
  logic [HW-1:0] hold_q, hold_d;
  char_t         char_q, char_d;
  logic          done_q, done_d;
`ifdef CHAR_SEQ_BLANK_GAP_EN
  logic          gap_q, gap_d;   // current HOLD belongs to the blank gap
`endif

  char_t rd_data;
  logic  final_tick;
  logic  last_idx;

  char_seq_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (idx_q),
    .rd_data_o (rd_data)
  );

  // The HOLD_TICKS-th tick of a hold: counter is at 1 (or already 0).
  assign final_tick = tick60 && (hold_q <= HW'(1));
  assign last_idx   = ({1'b0, idx_q} == (len_q - (AW+1)'(1)));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    loop_d  = loop_q;
    hold_d  = hold_q;
    char_d  = char_q;
    done_d  = 1'b0;
`ifdef CHAR_SEQ_BLANK_GAP_EN
    gap_d   = gap_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (start_len != '0) begin
            state_d = ST_EMIT;
            idx_d   = '0;
            len_d   = (start_len > DEPTH_L) ? DEPTH_L : start_len;
            loop_d  = loop;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      ST_EMIT: begin
        // char_out shows rd_data combinationally this cycle; latch it so the
        // value is held afterwards even if the buffer entry is rewritten.
        char_d  = rd_data;
        hold_d  = HOLD_L;
        state_d = ST_HOLD;
      end

      ST_HOLD: begin
        if (tick60) begin
          if (final_tick) begin
`ifdef CHAR_SEQ_BLANK_GAP_EN
            if (gap_q) begin
              gap_d   = 1'b0;
              idx_d   = '0;
              state_d = ST_EMIT;
            end else
`endif
            if (!last_idx) begin
              idx_d   = idx_q + AW'(1);
              state_d = ST_EMIT;
            end else if (loop_q) begin
`ifdef CHAR_SEQ_BLANK_GAP_EN
              state_d = ST_GAP;
`else
              idx_d   = '0;
              state_d = ST_EMIT;
`endif
            end else begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            hold_d = (hold_q != '0) ? hold_q - HW'(1) : '0;
          end
        end
      end

      ST_GAP: begin
        char_d  = BLANK_CHAR;
        hold_d  = HOLD_L;
        state_d = ST_HOLD;
`ifdef CHAR_SEQ_BLANK_GAP_EN
        gap_d   = 1'b1;
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    // stop beats start and any same-cycle final tick; char_out is left alone
    if (stop) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
`ifdef CHAR_SEQ_BLANK_GAP_EN
      gap_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      hold_q  <= '0;
      char_q  <= '0;
      done_q  <= 1'b0;
`ifdef CHAR_SEQ_BLANK_GAP_EN
      gap_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      hold_q  <= hold_d;
      char_q  <= char_d;
      done_q  <= done_d;
`ifdef CHAR_SEQ_BLANK_GAP_EN
      gap_q   <= gap_d;
`endif
    end
  end

  assign char_valid = (state_q == ST_EMIT) || (state_q == ST_GAP);
  assign char_out   = (state_q == ST_EMIT) ? rd_data :
                      (state_q == ST_GAP)  ? BLANK_CHAR : char_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_char_sequencer.sv
// -----------------------------------------------------------------------------
// tb_char_sequencer
//   Directed bench for char_sequencer (DEPTH=16, HOLD_TICKS=2). Expected output
//   events are queued when stimulus is issued; a negedge monitor pops and
//   compares every char_valid strobe and done pulse. Queue entry encoding:
//   bit 7 set = done pulse, otherwise bits 6:0 = expected character.
// -----------------------------------------------------------------------------
module tb_char_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam logic [7:0] EV_DONE = 8'h80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          tick_a = 1'b0, tick_m = 1'b0, tick_auto = 1'b1;
  logic          tick60;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [6:0]    wr_data = '0;
  logic          start = 1'b0;
  logic [AW:0]   start_len = '0;
  logic          loop = 1'b0;
  logic          stop = 1'b0;
  logic          char_valid, busy, done;
  logic [6:0]    char_out;
  logic [1:0]    dbg_state;

  assign tick60 = tick_a | tick_m;

  char_sequencer #(.DEPTH(DEPTH), .HOLD_TICKS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick60     (tick60),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .start_len  (start_len),
    .loop       (loop),
    .stop       (stop),
    .char_valid (char_valid),
    .char_out   (char_out),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // tick60: one clk wide, every 4 clks while tick_auto is set
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      cnt++;
      tick_a = tick_auto && ((cnt % 4) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_event(input string name, input logic [7:0] act);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected event %0h, nothing expected at %0t", name, act, $time);
    end else begin
      e = exp_q.pop_front();
      check(name, {24'h0, act}, {24'h0, e});
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (char_valid) mon_event("char_strobe", {1'b0, char_out});
      if (done)       mon_event("done_pulse", EV_DONE);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [6:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    cyc();
    wr_en   = 1'b0;
  endtask

  // Returns in the cycle after the start was sampled.
  task automatic do_start(input int len, input logic lp);
    start     = 1'b1;
    start_len = (AW+1)'(len);
    loop      = lp;
    cyc();
    start     = 1'b0;
    loop      = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600; i++) begin
      if (exp_q.size() == 0 && !busy) break;
      cyc();
    end
    check(name, exp_q.size(), 0);
    check({name, "_idle"}, busy, 1'b0);
  endtask

  // Waits until every queued strobe is seen (lands in the HOLD after the last
  // EMIT), then stops and checks the abort behaviour.
  task automatic stop_in_hold(input string name, input logic [6:0] last_ch);
    for (int i = 0; i < 600; i++) begin
      cyc();
      if (exp_q.size() == 0) break;
    end
    check({name, "_seen_all"}, exp_q.size(), 0);
    check({name, "_in_hold"}, dbg_state, 2'd2);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    check({name, "_busy_after_stop"}, busy, 1'b0);
    check({name, "_no_done"}, done, 1'b0);
    check({name, "_char_kept"}, char_out, last_ch);
    repeat (20) cyc();
    check({name, "_still_kept"}, char_out, last_ch);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] seq2[4];
    logic [7:0] seq5[$];
    int k_restart;
    int n;

`ifdef CHAR_SEQ_BLANK_GAP_EN
    seq2 = '{8'h48, 8'h49, 8'h20, 8'h48};
    seq5 = '{8'h48, 8'h4F, 8'h20, 8'h48, 8'h4F, 8'h20, 8'h5A};
    k_restart = 4;
`else
    seq2 = '{8'h48, 8'h49, 8'h48, 8'h49};
    seq5 = '{8'h48, 8'h4F, 8'h48, 8'h4F, 8'h5A};
    k_restart = 3;
`endif

    repeat (3) cyc();
    reset = 1'b0;
    check("rst_char_valid", char_valid, 1'b0);
    check("rst_char_out", char_out, 7'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_state", dbg_state, 2'd0);

    // 1) "HI", no loop
    wr(0, 7'h48);
    wr(1, 7'h49);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    exp_q.push_back(EV_DONE);
    do_start(2, 1'b0);
    check("t1_latency_valid", char_valid, 1'b1);
    check("t1_latency_char", char_out, 7'h48);
    check("t1_busy", busy, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      cyc();
    end
    check("t1_done_with_idle", done, 1'b1);
    check("t1_char_held", char_out, 7'h49);
    drain("t1_drain");

    // 2) loop, then stop mid-hold
    for (int i = 0; i < 4; i++) exp_q.push_back(seq2[i]);
    do_start(2, 1'b1);
    stop_in_hold("t2", seq2[3][6:0]);
    drain("t2_drain");

    // 3) zero length, then over-long length clamped to DEPTH
    exp_q.push_back(EV_DONE);
    do_start(0, 1'b0);
    check("t3_len0_done", done, 1'b1);
    check("t3_len0_no_valid", char_valid, 1'b0);
    check("t3_len0_busy", busy, 1'b0);
    cyc();
    check("t3_len0_done_one_clk", done, 1'b0);
    for (int i = 0; i < DEPTH; i++) wr(i, 7'(8'h41 + i));
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(8'h41 + i));
    exp_q.push_back(EV_DONE);
    do_start(31, 1'b0);
    drain("t3_len31_drain");

    // 4) start while busy is ignored
    wr(0, 7'h48);
    wr(1, 7'h49);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    exp_q.push_back(EV_DONE);
    do_start(2, 1'b0);
    cyc();
    start = 1'b1; start_len = 5'd1; loop = 1'b1;
    cyc();
    start = 1'b0; loop = 1'b0;
    check("t4_still_busy", busy, 1'b1);
    drain("t4_drain");

    // 5) writes during playback
    wr(0, 7'h48);
    wr(1, 7'h49);
    for (int i = 0; i < seq5.size(); i++) exp_q.push_back(seq5[i]);
    do_start(2, 1'b1);
    cyc();
    wr(1, 7'h4F);
    n = 1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (char_valid) begin
        n++;
        if (n == k_restart) break;
      end
    end
    check("t5_found_restart", n, k_restart);
    wr(0, 7'h5A);   // lands at the end of the restart EMIT cycle
    stop_in_hold("t5", 7'h5A);
    drain("t5_drain");

    // 6a) reset during HOLD
    wr(0, 7'h48);
    exp_q.push_back(8'h48);
    do_start(2, 1'b0);
    cyc();
    check("t6_in_hold", dbg_state, 2'd2);
    reset = 1'b1;
    cyc();
    check("t6_rst_valid", char_valid, 1'b0);
    check("t6_rst_char", char_out, 7'h00);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_done", done, 1'b0);
    reset = 1'b0;
    repeat (10) cyc();
    check("t6_rst_no_done", done, 1'b0);
    check("t6_rst_queue", exp_q.size(), 0);

    // 6b) tick in the EMIT cycle does not count
    tick_auto = 1'b0;
    repeat (2) cyc();
    exp_q.push_back(8'h48);
    exp_q.push_back(EV_DONE);
    do_start(1, 1'b0);
    tick_m = 1'b1;   // sampled at the end of the EMIT cycle
    cyc();
    tick_m = 1'b0;
    repeat (2) cyc();
    tick_m = 1'b1;   // first counted tick
    cyc();
    tick_m = 1'b0;
    check("t6_busy_after_tick1", busy, 1'b1);
    check("t6_no_done_tick1", done, 1'b0);
    repeat (3) cyc();
    check("t6_waiting", busy, 1'b1);
    tick_m = 1'b1;   // second counted tick ends the hold
    cyc();
    tick_m = 1'b0;
    check("t6_done_tick2", done, 1'b1);
    check("t6_idle_tick2", busy, 1'b0);
    tick_auto = 1'b1;
    drain("t6_drain");

    repeat (5) cyc();
    check("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
